// File: rtl/operand_entry_pkg.sv
// Shared state encodings and sizing helpers for the operand-entry front end.
package operand_entry_pkg;

    localparam logic [1:0] S_A   = 2'd0;
    localparam logic [1:0] S_B   = 2'd1;
    localparam logic [1:0] S_F   = 2'd2;
    localparam logic [1:0] S_RUN = 2'd3;

    function automatic int cnt_width(input int debounce);
        return $clog2(debounce + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability counter for one active-low key.
// Emits a single-cycle press pulse on each accepted release-to-pressed transition.
module key_debounce
    import operand_entry_pkg::*;
#(
    parameter int debounce = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int             CW   = cnt_width(debounce);
    localparam logic [CW-1:0]  LAST = CW'(debounce - 1);

    logic          s1_q, s2_q;
    logic          stable_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            s1_q    <= key_n;
            s2_q    <= s1_q;
            press_q <= 1'b0;
            if (s2_q != stable_q) begin
                // The edge that would bring the count to debounce flips the level instead.
                if (cnt_q == LAST) begin
                    stable_q <= s2_q;
                    cnt_q    <= '0;
                    press_q  <= stable_q & ~s2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/operand_entry.sv
// Walks the user through entering A, B and the function code using enter/back keys,
// presenting registered operands and a valid flag to the downstream ALU block.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int width    = 6,
    parameter int debounce = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] sw,
    input  logic             key_enter_n,
    input  logic             key_back_n,
    output logic [width-1:0] a,
    output logic [width-1:0] b,
    output logic [2:0]       func,
    output logic             valid,
    output logic [1:0]       stage
);

    logic             enter_p, back_p;
    logic [1:0]       state_q;
    logic [width-1:0] a_q, b_q;
    logic [2:0]       func_q;
    logic             valid_q;
    logic [2:0]       sw_func;

    key_debounce #(.debounce(debounce)) u_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_enter_n),
        .press (enter_p)
    );

    key_debounce #(.debounce(debounce)) u_back (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_back_n),
        .press (back_p)
    );

    generate
        if (width >= 3) begin : g_func_wide
            assign sw_func = sw[2:0];
        end else begin : g_func_narrow
            assign sw_func = {{(3 - width){1'b0}}, sw};
        end
    endgenerate

    // Coincident enter and back pulses cancel each other out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            func_q  <= '0;
            valid_q <= 1'b0;
        end else if (enter_p && !back_p) begin
            case (state_q)
                S_A: begin
                    a_q     <= sw;
                    state_q <= S_B;
                    valid_q <= 1'b0;
                end
                S_B: begin
                    b_q     <= sw;
                    state_q <= S_F;
                    valid_q <= 1'b0;
                end
                S_F: begin
                    func_q  <= sw_func;
                    state_q <= S_RUN;
                    valid_q <= 1'b1;
                end
                default: begin
                    state_q <= S_A;
                    valid_q <= 1'b0;
                end
            endcase
        end else if (back_p && !enter_p) begin
            valid_q <= 1'b0;
            case (state_q)
                S_A:     state_q <= S_A;
                S_B:     state_q <= S_A;
                S_F:     state_q <= S_B;
                default: state_q <= S_F;
            endcase
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign func  = func_q;
    assign valid = valid_q;
    assign stage = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with debounce=4, width=6.
module tb_operand_entry;

    localparam int W  = 6;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw;
    logic         key_enter_n, key_back_n;
    logic [W-1:0] a, b;
    logic [2:0]   func;
    logic         valid;
    logic [1:0]   stage;

    int n_chk  = 0;
    int n_fail = 0;

    operand_entry #(.width(W), .debounce(DB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw          (sw),
        .key_enter_n (key_enter_n),
        .key_back_n  (key_back_n),
        .a           (a),
        .b           (b),
        .func        (func),
        .valid       (valid),
        .stage       (stage)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Key goes low just after an edge, so the next edge is edge 0; update lands at edge 2+DB.
    task automatic press(input bit is_back, input logic [1:0] st_before, input logic [1:0] st_after);
        if (is_back) key_back_n = 1'b0;
        else         key_enter_n = 1'b0;
        tick(DB + 2);
        chk("stage_pre_edge", stage, st_before);
        tick(1);
        chk("stage_at_edge", stage, st_after);
        key_back_n  = 1'b1;
        key_enter_n = 1'b1;
        tick(10);
    endtask

    initial begin
        rst_n       = 1'b0;
        sw          = W'($urandom);
        key_enter_n = 1'($urandom);
        key_back_n  = 1'($urandom);
        #23;
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_func", func, 0);
        chk("rst_valid", valid, 0);
        chk("rst_stage", stage, 0);

        tick(1);
        key_enter_n = 1'b1;
        key_back_n  = 1'b1;
        rst_n       = 1'b1;
        tick(10);
        chk("idle_stage", stage, 0);
        chk("idle_valid", valid, 0);
        chk("idle_a", a, 0);

        // Full entry sequence
        sw = 6'd13;       press(1'b0, 2'd0, 2'd1);
        chk("entry_a", a, 13);
        sw = 6'd42;       press(1'b0, 2'd1, 2'd2);
        chk("entry_b", b, 42);
        sw = 6'b000101;   press(1'b0, 2'd2, 2'd3);
        chk("entry_a2", a, 13);
        chk("entry_b2", b, 42);
        chk("entry_func", func, 5);
        chk("entry_valid", valid, 1);

        // Back navigation, data must be retained
        sw = 6'd63;
        press(1'b1, 2'd3, 2'd2);
        chk("back_valid", valid, 0);
        press(1'b1, 2'd2, 2'd1);
        press(1'b1, 2'd1, 2'd0);
        press(1'b1, 2'd0, 2'd0);
        chk("back_a", a, 13);
        chk("back_b", b, 42);
        chk("back_func", func, 5);

        // Bounce rejection: 2-cycle low glitches never reach the count
        sw = 6'd21;
        for (int i = 0; i < 5; i++) begin
            key_enter_n = 1'b0; tick(2);
            key_enter_n = 1'b1; tick(2);
        end
        tick(10);
        chk("bounce_stage", stage, 0);
        chk("bounce_a", a, 13);
        key_enter_n = 1'b0;
        tick(10);
        chk("hold_stage", stage, 1);
        chk("hold_a", a, 21);
        tick(20);
        chk("hold_once", stage, 1);
        key_enter_n = 1'b1;
        tick(10);

        // Simultaneous keys in S_B
        sw = 6'd7;
        key_enter_n = 1'b0;
        key_back_n  = 1'b0;
        tick(12);
        chk("simul_stage", stage, 1);
        chk("simul_b", b, 42);
        key_enter_n = 1'b1;
        key_back_n  = 1'b1;
        tick(10);

        // Reset mid-count in S_F
        sw = 6'd50;
        press(1'b0, 2'd1, 2'd2);
        chk("mid_b", b, 50);
        key_enter_n = 1'b0;
        tick(DB + 1);
        rst_n = 1'b0;
        #1;
        chk("arst_stage", stage, 0);
        chk("arst_a", a, 0);
        chk("arst_b", b, 0);
        chk("arst_valid", valid, 0);
        tick(1);
        sw    = 6'd33;
        rst_n = 1'b1;
        tick(DB + 2);
        chk("rel_pre", stage, 0);
        tick(1);
        chk("rel_stage", stage, 1);
        chk("rel_a", a, 33);
        key_enter_n = 1'b1;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
# operand_entry

Sequential operand-entry front end for the ALU display top level. It sits directly upstream of the ALU/BCD/7-segment block. It takes the board switches and two active-low push buttons, and walks the user through entering operand A, operand B and the function code. It presents stable registered `a`, `b` and `func` values plus a `valid` flag to the downstream block. Button inputs are synchronised and debounced internally, so each physical press advances the entry sequence exactly once.

## Interface
Parameters:
- `width`, default 6: operand width; must match the downstream operand width.
- `debounce`, default 50000: number of consecutive stable cycles required to accept a button level change; minimum 1.

Ports:
- `clk`, input, 1: single clock for all logic.
- `rst_n`, input, 1: reset; asynchronous, active-low.
- `sw`, input, `width`: raw switch value, treated as quasi-static; sampled only on an accepted press.
- `key_enter_n`, input, 1: raw enter button, active-low, asynchronous to `clk`.
- `key_back_n`, input, 1: raw back button, active-low, asynchronous to `clk`.
- `a`, output, `width`: registered operand A.
- `b`, output, `width`: registered operand B.
- `func`, output, 3: registered function code.
- `valid`, output, 1: high while in RUN state.
- `stage`, output, 2: current state encoding, for status LEDs.

## Operation
- Each key passes through a 2-flop synchroniser, then a debouncer:
  - The debouncer holds a stable level, reset value 1 (released).
  - A counter increments while the synchronised level differs from the stable level, and clears to 0 whenever they match.
  - When the counter reaches `debounce`, the stable level flips and the counter clears.
  - A 1-to-0 flip of the stable level produces a one-cycle `press` pulse. A 0-to-1 flip (release) produces nothing.
- FSM states, in `stage` encoding order: S_A=0, S_B=1, S_F=2, S_RUN=3. Reset state is S_A.
- On an enter press:
  - S_A: `a` <= `sw`, go to S_B.
  - S_B: `b` <= `sw`, go to S_F.
  - S_F: `func` <= `sw[2:0]`, go to S_RUN.
  - S_RUN: go to S_A. `a`/`b`/`func` are retained, not cleared.
- On a back press:
  - S_A: stay in S_A.
  - S_B: go to S_A.
  - S_F: go to S_B.
  - S_RUN: go to S_F.
  - Back never modifies `a`/`b`/`func`.
- If enter and back pulses occur in the same cycle, both are ignored and there is no state change.
- `valid` = (state == S_RUN), registered alongside the state.
- If `width` < 3, `func` takes `sw` zero-extended.

## Timing
- Reset values: `a`=0, `b`=0, `func`=0, `valid`=0, `stage`=0. Synchroniser flops = 1, stable levels = 1, counters = 0.
- Press latency: let edge 0 be the first edge at which the raw key is sampled low, with the key held low thereafter.
  - The synchronised low appears after edge 1.
  - `press` is high for the cycle following edge 1+`debounce`.
  - State, data registers, `valid` and `stage` update at edge 2+`debounce`.
- A low glitch shorter than `debounce` synchronised cycles produces no press.
- A key held indefinitely produces exactly one press.
- A release must itself be stable for `debounce` cycles before another press can be accepted.
- Outputs change only on a clock edge. They are glitch-free and hold between accepted presses.
- Reset asserted mid-count or mid-entry forces the reset values immediately, independent of `clk`. After deassertion, a key still held low is accepted as a new press after the full debounce latency.

## Structure
- Package `operand_entry_pkg` holds:
  - state localparams S_A, S_B, S_F, S_RUN, 2 bits;
  - a function returning counter width as `$clog2(debounce+1)`.
- One sub-module, `key_debounce`, contains the synchroniser, counter, stable level and press pulse. It has parameter `debounce`, inputs `clk`/`rst_n`/`key_n`, and output `press`. It is instantiated twice.
- The top module contains the FSM and the data registers only.

## Test plan
All scenarios use `debounce`=4 and `width`=6.
- Reset: hold `rst_n`=0 with random inputs -> `a`=0, `b`=0, `func`=0, `valid`=0, `stage`=0. Release reset -> outputs unchanged with keys idle.
- Full entry: `sw`=6'd13, press enter; `sw`=6'd42, press enter; `sw`=6'b000101, press enter.
  - Expect `a`=13, `b`=42, `func`=5, `valid`=1, `stage`=3.
  - Each update lands at edge 6 after the key goes low.
- Bounce rejection: toggle `key_enter_n` low/high every 2 cycles for 20 cycles, then hold high -> no state change.
  - Then hold low 10 cycles -> exactly one advance.
- Back navigation: from S_RUN, back -> `stage`=2, `valid`=0; back twice more -> `stage`=0; back again -> stays 0.
  - `a`/`b`/`func` are unchanged throughout.
- Simultaneous keys: drive both keys low at the same edge from S_B -> `stage` stays 1 and `b` is unchanged.
- Reset mid-operation: in S_F with enter counter at 3, assert `rst_n`=0 asynchronously -> all outputs are reset values before the next edge.
  - Release reset with enter still held -> `stage`=1 at edge 6 after release, and `a`=`sw`.
